// File: rtl/boid_frame_scanner_if.sv
// Scanner-side bus: frame request, engine position check, frame-buffer write
// port and step/status strobes.
interface boid_frame_scanner_if #(parameter int ADDR_W = 19);
  logic              frame_start;
  logic              is_boid_here;
  logic [31:0]       x_chk;
  logic [31:0]       y_chk;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              step_en;
  logic              busy;
  logic              frame_done;

  modport master (
    output frame_start, is_boid_here,
    input  x_chk, y_chk, wr_en, wr_addr, wr_data, step_en, busy, frame_done
  );

  modport slave (
    input  frame_start, is_boid_here,
    output x_chk, y_chk, wr_en, wr_addr, wr_data, step_en, busy, frame_done
  );
endinterface

// File: rtl/boid_frame_scanner.sv
// Raster-scans the frame, asks the boid engine about each pixel and writes one
// colour byte per pixel to the frame buffer, then steps the engine once.
module boid_frame_scanner #(
  parameter int         H_RES      = 640,
  parameter int         V_RES      = 480,
  parameter int         CHK_LAT    = 1,
  parameter int         ADDR_W     = 19,
  parameter logic [7:0] BOID_COLOR = 8'hFF,
  parameter logic [7:0] BG_COLOR   = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  boid_frame_scanner_if.slave bus
);
  localparam int          STG    = (CHK_LAT > 0) ? CHK_LAT : 1;
  localparam logic [31:0] X_LAST = 32'(H_RES - 1);
  localparam logic [31:0] Y_LAST = 32'(V_RES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, STEP} state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [STG-1:0]              vld_pipe_q;
  logic [STG-1:0][ADDR_W-1:0]  adr_pipe_q;
  logic                        issue, tap_vld, inflight;
  logic [ADDR_W-1:0]           tap_adr;
  logic                        wr_en_q;
  logic [ADDR_W-1:0]           wr_addr_q;
  logic [7:0]                  wr_data_q;

  assign issue = (state_q == SCAN);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (bus.frame_start) state_d = SCAN;
      end
      SCAN: begin
        // Linear address runs alongside x/y so no multiplier is needed.
        if (x_q == X_LAST) begin
          if (y_q == Y_LAST) begin
            state_d = DRAIN;
          end else begin
            x_d    = '0;
            y_d    = y_q + 32'd1;
            addr_d = addr_q + 1'b1;
          end
        end else begin
          x_d    = x_q + 32'd1;
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN:   if (!inflight) state_d = STEP;
      STEP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
    end
  end

  // Delay line aligning each issued address with its check result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q <= '0;
      adr_pipe_q <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      adr_pipe_q[0] <= addr_q;
      for (int i = 1; i < STG; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        adr_pipe_q[i] <= adr_pipe_q[i-1];
      end
    end
  end

  assign tap_vld  = (CHK_LAT == 0) ? issue  : vld_pipe_q[STG-1];
  assign tap_adr  = (CHK_LAT == 0) ? addr_q : adr_pipe_q[STG-1];
  assign inflight = (CHK_LAT == 0) ? 1'b0   : |vld_pipe_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= tap_vld;
      if (tap_vld) begin
        wr_addr_q <= tap_adr;
        wr_data_q <= bus.is_boid_here ? BOID_COLOR : BG_COLOR;
      end
    end
  end

  assign bus.x_chk      = x_q;
  assign bus.y_chk      = y_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.step_en    = (state_q == STEP);
  assign bus.frame_done = (state_q == STEP);
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_boid_frame_scanner.sv
// Scoreboard bench: three scanners (check latency 0, 1, 3) on an 8x4 frame,
// each fed by a small engine model that reports a boid only at (3,2).
module tb_boid_frame_scanner;
  localparam int H = 8, V = 4, N = 32, AW = 19;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic boid_on = 1'b0;
  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boid_frame_scanner_if #(.ADDR_W(AW)) b0 ();
  boid_frame_scanner_if #(.ADDR_W(AW)) b1 ();
  boid_frame_scanner_if #(.ADDR_W(AW)) b3 ();

  boid_frame_scanner #(.H_RES(H), .V_RES(V), .CHK_LAT(0), .ADDR_W(AW))
    u0 (.clk(clk), .reset(reset), .bus(b0.slave));
  boid_frame_scanner #(.H_RES(H), .V_RES(V), .CHK_LAT(1), .ADDR_W(AW))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  boid_frame_scanner #(.H_RES(H), .V_RES(V), .CHK_LAT(3), .ADDR_W(AW))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  // Engine model: result for a coordinate appears CHK_LAT cycles later.
  logic       h0, h1, h3;
  logic       d1 = 1'b0;
  logic [2:0] d3 = '0;
  assign h0 = boid_on && b0.x_chk == 32'd3 && b0.y_chk == 32'd2;
  assign h1 = boid_on && b1.x_chk == 32'd3 && b1.y_chk == 32'd2;
  assign h3 = boid_on && b3.x_chk == 32'd3 && b3.y_chk == 32'd2;
  always @(posedge clk) begin
    d1 <= h1;
    d3 <= {d3[1:0], h3};
  end
  assign b0.is_boid_here = h0;
  assign b1.is_boid_here = d1;
  assign b3.is_boid_here = d3[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  wr_t q0[$], q1[$], q3[$];

  task automatic push(input int which, input bit on);
    wr_t e;
    for (int k = 0; k < N; k++) begin
      e.a = AW'(k);
      e.d = (on && k == 19) ? 8'hFF : 8'h00;
      case (which)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q3.push_back(e);
      endcase
    end
  endtask

  // Monitors sample on the falling edge; cyc is the current cycle index.
  int fw1 = 0, lw1 = 0, wc1 = 0, sc1 = 0, stc1 = 0;
  int sc0 = 0, stc0 = 0, sc3 = 0, stc3 = 0;

  always @(negedge clk) begin : mon1
    wr_t e;
    if (!reset) begin
      if (b1.wr_en) begin
        if (q1.size() == 0) chk("u1_extra_wr", b1.wr_en, 1'b0);
        else begin
          e = q1.pop_front();
          chk("u1_addr", b1.wr_addr, e.a);
          chk("u1_data", b1.wr_data, e.d);
        end
        if (wc1 == 0) fw1 = cyc;
        lw1 = cyc;
        wc1++;
      end
      if (b1.step_en) begin sc1++; stc1 = cyc; end
      if (b1.step_en || b1.frame_done) chk("u1_fd_step", b1.frame_done, b1.step_en);
    end
  end

  always @(negedge clk) begin : mon0
    wr_t e;
    if (!reset) begin
      if (b0.wr_en) begin
        if (q0.size() == 0) chk("u0_extra_wr", b0.wr_en, 1'b0);
        else begin
          e = q0.pop_front();
          chk("u0_addr", b0.wr_addr, e.a);
          chk("u0_data", b0.wr_data, e.d);
        end
      end
      if (b0.step_en) begin sc0++; stc0 = cyc; end
    end
  end

  always @(negedge clk) begin : mon3
    wr_t e;
    if (!reset) begin
      if (b3.wr_en) begin
        if (q3.size() == 0) chk("u3_extra_wr", b3.wr_en, 1'b0);
        else begin
          e = q3.pop_front();
          chk("u3_addr", b3.wr_addr, e.a);
          chk("u3_data", b3.wr_data, e.d);
        end
      end
      if (b3.step_en) begin sc3++; stc3 = cyc; end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_zero1(input string tag);
    chk({tag, "_x"},    b1.x_chk, 32'd0);
    chk({tag, "_y"},    b1.y_chk, 32'd0);
    chk({tag, "_wen"},  b1.wr_en, 1'b0);
    chk({tag, "_wadr"}, b1.wr_addr, '0);
    chk({tag, "_wdat"}, b1.wr_data, 8'h00);
    chk({tag, "_step"}, b1.step_en, 1'b0);
    chk({tag, "_busy"}, b1.busy, 1'b0);
    chk({tag, "_fd"},   b1.frame_done, 1'b0);
  endtask

  int t;

  initial begin
    b0.frame_start = 1'b0;
    b1.frame_start = 1'b0;
    b3.frame_start = 1'b0;

    // Reset hold and idle after release
    tick(3);
    chk_zero1("rst");
    reset = 1'b0;
    tick(12);
    chk_zero1("idle");
    chk("idle_steps", sc1, 0);

    // Plain frame, no boids
    wc1 = 0; sc1 = 0;
    push(1, 1'b0);
    b1.frame_start = 1'b1; t = cyc;
    tick(1); b1.frame_start = 1'b0;
    chk("f1_busy_t1", b1.busy, 1'b1);
    tick(34);
    chk("f1_first_wr", fw1, t + 3);
    chk("f1_last_wr", lw1, t + 34);
    chk("f1_wr_cnt", wc1, N);
    chk("f1_step_cyc", stc1, t + 35);
    chk("f1_step_cnt", sc1, 1);
    chk("f1_busy_t35", b1.busy, 1'b1);
    tick(1);
    chk("f1_busy_t36", b1.busy, 1'b0);
    chk("f1_q_empty", q1.size(), 0);

    // One boid at (3,2) on all three latencies
    boid_on = 1'b1;
    sc0 = 0; sc1 = 0; sc3 = 0; wc1 = 0;
    push(0, 1'b1); push(1, 1'b1); push(3, 1'b1);
    b0.frame_start = 1'b1; b1.frame_start = 1'b1; b3.frame_start = 1'b1; t = cyc;
    tick(1);
    b0.frame_start = 1'b0; b1.frame_start = 1'b0; b3.frame_start = 1'b0;
    tick(40);
    chk("l0_step_cyc", stc0, t + 34);
    chk("l1_step_cyc", stc1, t + 35);
    chk("l3_step_cyc", stc3, t + 37);
    chk("l0_step_cnt", sc0, 1);
    chk("l1_step_cnt", sc1, 1);
    chk("l3_step_cnt", sc3, 1);
    chk("l0_q_empty", q0.size(), 0);
    chk("l1_q_empty", q1.size(), 0);
    chk("l3_q_empty", q3.size(), 0);
    boid_on = 1'b0;

    // frame_start held high across two frames
    sc1 = 0; wc1 = 0;
    push(1, 1'b0); push(1, 1'b0);
    b1.frame_start = 1'b1; t = cyc;
    tick(35);
    chk("hold_step1", sc1, 1);
    tick(1);
    chk("hold_busy_t36", b1.busy, 1'b0);
    tick(1);
    chk("hold_x_t37", b1.x_chk, 32'd0);
    chk("hold_y_t37", b1.y_chk, 32'd0);
    chk("hold_busy_t37", b1.busy, 1'b1);
    chk("hold_steps_t37", sc1, 1);
    tick(1);
    chk("hold_x_t38", b1.x_chk, 32'd1);
    b1.frame_start = 1'b0;
    tick(40);
    chk("hold_step2_cyc", stc1, t + 71);
    chk("hold_steps", sc1, 2);
    chk("hold_wr_cnt", wc1, 2 * N);
    chk("hold_q_empty", q1.size(), 0);

    // Asynchronous reset while pixel 10 is presented
    sc1 = 0; wc1 = 0;
    push(1, 1'b0);
    b1.frame_start = 1'b1; t = cyc;
    tick(1); b1.frame_start = 1'b0;
    tick(10);
    chk("mid_x", b1.x_chk, 32'd2);
    chk("mid_y", b1.y_chk, 32'd1);
    chk("mid_q_left", q1.size(), 23);
    reset = 1'b1;
    #1;
    chk_zero1("async");
    q1.delete();
    tick(3);
    reset = 1'b0;
    tick(3);
    chk("mid_wr_cnt", wc1, 9);
    chk("mid_steps", sc1, 0);

    wc1 = 0;
    push(1, 1'b0);
    b1.frame_start = 1'b1; t = cyc;
    tick(1); b1.frame_start = 1'b0;
    tick(37);
    chk("re_first_wr", fw1, t + 3);
    chk("re_wr_cnt", wc1, N);
    chk("re_steps", sc1, 1);
    chk("re_q_empty", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
